// File: rtl/qa_shim_rd_credit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qa_shim_rd_credit_pkg
//  Brief    : Shared CCI widths and read-credit sizing for the QA driver.
//  Revision : 1.0
// ============================================================================
package qa_shim_rd_credit_pkg;

    localparam int c_CCI_TX_HDR_WIDTH   = 61;
    localparam int c_MAX_RD_IN_FLIGHT   = 64;

    // Counter must represent 0..max inclusive.
    function automatic int cred_width(input int max_rd);
        return $clog2(max_rd + 1);
    endfunction

    localparam int c_CRED_W = cred_width(c_MAX_RD_IN_FLIGHT);

endpackage
`default_nettype wire

// File: rtl/qa_shim_rd_credit_if.sv
`default_nettype none
// ============================================================================
//  Module   : qa_shim_rd_credit_if
//  Brief    : Channel 0 read buffer, QLP request and credit status bundle.
//  Revision : 1.0
// ============================================================================
interface qa_shim_rd_credit_if #(
    parameter int HDR_W  = 61,
    parameter int CRED_W = 7
);
    logic              buf_c0_valid;
    logic [HDR_W-1:0]  buf_c0_hdr;
    logic              deq_c0;
    logic              qlp_c0_almfull;
    logic              qlp_c0_rd_valid;
    logic [HDR_W-1:0]  qlp_c0_hdr;
    logic              qlp_c0_rx_rd_valid;
    logic [CRED_W-1:0] credits_avail;
    logic              credit_err;

    modport master (
        input  buf_c0_valid, buf_c0_hdr, qlp_c0_almfull, qlp_c0_rx_rd_valid,
        output deq_c0, qlp_c0_rd_valid, qlp_c0_hdr, credits_avail, credit_err
    );

    modport slave (
        output buf_c0_valid, buf_c0_hdr, qlp_c0_almfull, qlp_c0_rx_rd_valid,
        input  deq_c0, qlp_c0_rd_valid, qlp_c0_hdr, credits_avail, credit_err
    );
endinterface
`default_nettype wire

// File: rtl/qa_shim_rd_credit_counter.sv
`default_nettype none
// ============================================================================
//  Module   : qa_drv_prim_credit_counter
//  Brief    : Saturating credit counter with sticky overflow on excess returns.
//  Revision : 1.0
// ============================================================================
module qa_drv_prim_credit_counter #(
    parameter int MAX_CREDITS = 64,
    parameter int CNT_W       = 7
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              take,
    input  wire              give,
    output logic [CNT_W-1:0] avail,
    output logic             nonzero,
    output logic             overflow
);
    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_CREDITS);

    logic [CNT_W-1:0] r_avail;
    logic             r_overflow;

    // Simultaneous take and give cancel; a give at full is an accounting error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_avail    <= c_MAX;
            r_overflow <= 1'b0;
        end else if (take && !give) begin
            if (r_avail != '0) begin
                r_avail <= r_avail - 1'b1;
            end
        end else if (give && !take) begin
            if (r_avail == c_MAX) begin
                r_overflow <= 1'b1;
            end else begin
                r_avail <= r_avail + 1'b1;
            end
        end
    end

    assign avail    = r_avail;
    assign nonzero  = (r_avail != '0);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/qa_shim_rd_credit.sv
`default_nettype none
// ============================================================================
//  Module   : qa_shim_rd_credit
//  Brief    : Credit-gated channel 0 read issue from AFU buffer to the QLP.
//  Revision : 1.0
// ============================================================================
module qa_shim_rd_credit
    import qa_shim_rd_credit_pkg::*;
#(
    parameter int CCI_TX_HDR_WIDTH = c_CCI_TX_HDR_WIDTH,
    parameter int MAX_RD_IN_FLIGHT = c_MAX_RD_IN_FLIGHT
) (
    input  wire                 clk,
    input  wire                 reset,
    qa_shim_rd_credit_if.master bus
);
    localparam int CRED_W = cred_width(MAX_RD_IN_FLIGHT);

    logic                        w_issue;
    logic                        w_nonzero;
    logic [CRED_W-1:0]           w_avail;
    logic                        w_overflow;
    logic                        r_rd_valid;
    logic [CCI_TX_HDR_WIDTH-1:0] r_hdr;

    assign w_issue = bus.buf_c0_valid && !bus.qlp_c0_almfull && w_nonzero && !reset;

    qa_drv_prim_credit_counter #(
        .MAX_CREDITS (MAX_RD_IN_FLIGHT),
        .CNT_W       (CRED_W)
    ) u_credit (
        .clk      (clk),
        .rst      (reset),
        .take     (w_issue),
        .give     (bus.qlp_c0_rx_rd_valid),
        .avail    (w_avail),
        .nonzero  (w_nonzero),
        .overflow (w_overflow)
    );

    // Header is only captured on issue so it holds while valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_hdr      <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_hdr <= bus.buf_c0_hdr;
            end
        end
    end

    assign bus.deq_c0          = w_issue;
    assign bus.qlp_c0_rd_valid = r_rd_valid;
    assign bus.qlp_c0_hdr      = r_hdr;
    assign bus.credits_avail   = w_avail;
    assign bus.credit_err      = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_qa_shim_rd_credit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qa_shim_rd_credit
//  Brief    : Directed self-checking bench for qa_shim_rd_credit.
//  Revision : 1.0
// ============================================================================
module tb_qa_shim_rd_credit;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    qa_shim_rd_credit_if #(.HDR_W(61), .CRED_W(3)) bus_a ();
    qa_shim_rd_credit_if #(.HDR_W(8),  .CRED_W(1)) bus_b ();

    qa_shim_rd_credit #(.CCI_TX_HDR_WIDTH(61), .MAX_RD_IN_FLIGHT(4)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    qa_shim_rd_credit #(.CCI_TX_HDR_WIDTH(8), .MAX_RD_IN_FLIGHT(1)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic exp_prev;
        logic alm;

        bus_a.buf_c0_valid       = 1'b1;
        bus_a.buf_c0_hdr         = 61'h1;
        bus_a.qlp_c0_almfull     = 1'b0;
        bus_a.qlp_c0_rx_rd_valid = 1'b0;
        bus_b.buf_c0_valid       = 1'b0;
        bus_b.buf_c0_hdr         = 8'h0;
        bus_b.qlp_c0_almfull     = 1'b0;
        bus_b.qlp_c0_rx_rd_valid = 1'b0;

        // Reset state
        tick(); tick();
        settle();
        chk("rst_credits", 64'(bus_a.credits_avail), 64'd4);
        chk("rst_rd_valid", 64'(bus_a.qlp_c0_rd_valid), 64'd0);
        chk("rst_hdr", 64'(bus_a.qlp_c0_hdr), 64'd0);
        chk("rst_err", 64'(bus_a.credit_err), 64'd0);
        chk("rst_deq", 64'(bus_a.deq_c0), 64'd0);

        // Fill from reset release: 4 issues then stall on credits
        tick(); rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                bus_a.buf_c0_hdr = 61'(i + 1);
            end
            settle();
            chk("fill_deq", 64'(bus_a.deq_c0), (i < 4) ? 64'd1 : 64'd0);
            chk("fill_credits", 64'(bus_a.credits_avail), 64'(4 - i));
            chk("fill_rd_valid", 64'(bus_a.qlp_c0_rd_valid), (i > 0) ? 64'd1 : 64'd0);
            if (i > 0) chk("fill_hdr", 64'(bus_a.qlp_c0_hdr), 64'(i));
        end
        tick(); settle();
        chk("stall_rd_valid", 64'(bus_a.qlp_c0_rd_valid), 64'd0);
        chk("stall_hdr_hold", 64'(bus_a.qlp_c0_hdr), 64'd4);
        chk("stall_deq", 64'(bus_a.deq_c0), 64'd0);

        // One response returns a credit usable the following cycle
        tick(); bus_a.qlp_c0_rx_rd_valid = 1'b1;
        settle();
        chk("ret_deq_same", 64'(bus_a.deq_c0), 64'd0);
        tick(); bus_a.qlp_c0_rx_rd_valid = 1'b0;
        settle();
        chk("ret_credits", 64'(bus_a.credits_avail), 64'd1);
        chk("ret_deq", 64'(bus_a.deq_c0), 64'd1);
        tick(); bus_a.buf_c0_valid = 1'b0;
        settle();
        chk("ret_rd_valid", 64'(bus_a.qlp_c0_rd_valid), 64'd1);
        chk("ret_hdr", 64'(bus_a.qlp_c0_hdr), 64'h5);
        chk("ret_credits0", 64'(bus_a.credits_avail), 64'd0);
        chk("novalid_deq", 64'(bus_a.deq_c0), 64'd0);

        // Bring credits to 2, then coincident issue/response for 10 cycles
        tick(); bus_a.qlp_c0_rx_rd_valid = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            bus_a.buf_c0_valid = 1'b1;
            bus_a.buf_c0_hdr   = 61'(32'h100 + k);
            settle();
            chk("coin_credits", 64'(bus_a.credits_avail), 64'd2);
            chk("coin_deq", 64'(bus_a.deq_c0), 64'd1);
            chk("coin_rd_valid", 64'(bus_a.qlp_c0_rd_valid), (k > 0) ? 64'd1 : 64'd0);
            if (k > 0) chk("coin_hdr", 64'(bus_a.qlp_c0_hdr), 64'(32'hFF + k));
        end
        tick();
        bus_a.buf_c0_valid       = 1'b0;
        bus_a.qlp_c0_rx_rd_valid = 1'b0;
        settle();
        chk("coin_last_hdr", 64'(bus_a.qlp_c0_hdr), 64'h109);
        chk("coin_end_credits", 64'(bus_a.credits_avail), 64'd2);

        // Almost-full window in cycles 3..7
        exp_prev = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            tick();
            alm = (j >= 3) && (j <= 7);
            bus_a.buf_c0_valid       = 1'b1;
            bus_a.buf_c0_hdr         = 61'(32'h200 + j);
            bus_a.qlp_c0_almfull     = alm;
            bus_a.qlp_c0_rx_rd_valid = !alm;
            settle();
            chk("alm_deq", 64'(bus_a.deq_c0), 64'(!alm));
            chk("alm_rd_valid", 64'(bus_a.qlp_c0_rd_valid), 64'(exp_prev));
            if (exp_prev) chk("alm_hdr", 64'(bus_a.qlp_c0_hdr), 64'(32'h200 + j - 1));
            chk("alm_credits", 64'(bus_a.credits_avail), 64'd2);
            exp_prev = !alm;
        end
        tick();
        bus_a.buf_c0_valid       = 1'b0;
        bus_a.qlp_c0_almfull     = 1'b0;
        bus_a.qlp_c0_rx_rd_valid = 1'b0;

        // Reset mid-operation with reads outstanding, then stale responses
        rst_a = 1'b1;
        tick(); rst_a = 1'b0;
        settle();
        chk("rr_credits", 64'(bus_a.credits_avail), 64'd4);
        for (int m = 0; m < 3; m++) begin
            tick();
            bus_a.buf_c0_valid = 1'b1;
            bus_a.buf_c0_hdr   = 61'(32'h300 + m);
        end
        tick(); bus_a.buf_c0_valid = 1'b0;
        settle();
        chk("rr_pre_credits", 64'(bus_a.credits_avail), 64'd1);
        tick(); rst_a = 1'b1; bus_a.buf_c0_valid = 1'b1;
        settle();
        chk("rr_deq_in_rst", 64'(bus_a.deq_c0), 64'd0);
        tick(); rst_a = 1'b0; bus_a.buf_c0_valid = 1'b0; bus_a.qlp_c0_rx_rd_valid = 1'b1;
        settle();
        chk("rr_post_credits", 64'(bus_a.credits_avail), 64'd4);
        chk("rr_post_err", 64'(bus_a.credit_err), 64'd0);
        chk("rr_post_rd_valid", 64'(bus_a.qlp_c0_rd_valid), 64'd0);
        chk("rr_post_hdr", 64'(bus_a.qlp_c0_hdr), 64'd0);
        for (int r = 0; r < 3; r++) begin
            tick();
            if (r == 2) bus_a.qlp_c0_rx_rd_valid = 1'b0;
            settle();
            chk("rr_err", 64'(bus_a.credit_err), 64'd1);
            chk("rr_sat_credits", 64'(bus_a.credits_avail), 64'd4);
        end

        // Single-credit instance: alternating issue and response
        tick(); rst_b = 1'b0;
        for (int n = 0; n < 6; n++) begin
            if (n > 0) tick();
            bus_b.buf_c0_valid       = 1'b1;
            bus_b.buf_c0_hdr         = 8'(n);
            bus_b.qlp_c0_rx_rd_valid = n[0];
            settle();
            chk("b_credits", 64'(bus_b.credits_avail), n[0] ? 64'd0 : 64'd1);
            chk("b_deq", 64'(bus_b.deq_c0), n[0] ? 64'd0 : 64'd1);
            chk("b_rd_valid", 64'(bus_b.qlp_c0_rd_valid), n[0] ? 64'd1 : 64'd0);
        end
        tick(); bus_b.buf_c0_valid = 1'b0; bus_b.qlp_c0_rx_rd_valid = 1'b0;
        settle();
        chk("b_err", 64'(bus_b.credit_err), 64'd0);
        chk("b_end_credits", 64'(bus_b.credits_avail), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qa_shim_rd_credit.md
QA_SHIM_RD_CREDIT -- requirements
Module: qa_shim_rd_credit

Interface
REQ-001 SHALL have parameter CCI_TX_HDR_WIDTH, default 61, the Tx request header width.
REQ-002 SHALL have parameter MAX_RD_IN_FLIGHT, default 64, the maximum number of outstanding reads (legal range 1..1024).
REQ-003 SHALL have localparam CRED_W = $clog2(MAX_RD_IN_FLIGHT+1).
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 buf_c0_valid  in  1  head of the upstream AFU-side channel 0 read buffer is valid.
REQ-007 buf_c0_hdr  in  CCI_TX_HDR_WIDTH  header at the head of that buffer.
REQ-008 deq_c0  out  1  combinational dequeue of the buffer head; drives the buffer's channel 0 dequeue input.
REQ-009 qlp_c0_almfull  in  1  QLP-side channel 0 almost-full.
REQ-010 qlp_c0_rd_valid  out  1  registered read request valid toward the QLP.
REQ-011 qlp_c0_hdr  out  CCI_TX_HDR_WIDTH  registered read request header.
REQ-012 qlp_c0_rx_rd_valid  in  1  one read response returned this cycle.
REQ-013 credits_avail  out  CRED_W  the current free read credits.
REQ-014 credit_err  out  1  sticky flag: a response arrived with no read outstanding.

Function
REQ-015 The block SHALL compute issue = buf_c0_valid && !qlp_c0_almfull && (credits_avail != 0) && !reset.
REQ-016 deq_c0 SHALL equal issue, combinationally, in the same cycle.
REQ-017 On issue, the next cycle SHALL have qlp_c0_rd_valid=1 and qlp_c0_hdr=buf_c0_hdr from the issue cycle (latency 1).
REQ-018 qlp_c0_rd_valid SHALL be 0 in any cycle following a non-issue cycle.
REQ-019 qlp_c0_hdr SHALL hold its last value when qlp_c0_rd_valid=0.
REQ-020 Back-to-back issue SHALL be allowed: at most one request per cycle, full throughput when unthrottled.
REQ-021 The credit counter SHALL decrement by 1 on issue alone.
REQ-022 The credit counter SHALL increment by 1 on qlp_c0_rx_rd_valid alone.
REQ-023 The credit counter SHALL be unchanged when issue and a response occur in the same cycle.
REQ-024 A returned credit SHALL be usable no earlier than the cycle after its response.
REQ-025 If a response arrives while credits_avail==MAX_RD_IN_FLIGHT and there is no issue: the counter SHALL stay at MAX, and credit_err SHALL set on the next cycle and hold until reset.
REQ-026 When qlp_c0_almfull rises, issue SHALL stop in that same cycle; no extra requests are sent.
REQ-027 If buf_c0_valid drops, no request SHALL be issued.
REQ-028 Header contents SHALL never be inspected or modified.

Reset
REQ-029 While reset=1: credits_avail=MAX_RD_IN_FLIGHT, qlp_c0_rd_valid=0, qlp_c0_hdr=0, credit_err=0, deq_c0=0.
REQ-030 If reset is asserted mid-operation, in-flight reads SHALL be forgotten.
REQ-031 Responses after reset for pre-reset reads SHALL follow REQ-025.
REQ-032 The first issue SHALL be possible in the first cycle with reset=0.

Structure
REQ-033 The default of MAX_RD_IN_FLIGHT and the CRED_W derivation SHALL live in the shared qa_driver package/header, alongside the CCI width constants.
REQ-034 The credit counter SHALL be one sub-module, qa_drv_prim_credit_counter, with ports: take, give, avail, nonzero, overflow.
REQ-035 The output request register SHALL be in the top module.
REQ-036 The block SHALL contain no FIFO; all buffering is upstream.

Verification (MAX_RD_IN_FLIGHT=4 unless stated)
REQ-037 Reset release with buf_c0_valid held high, hdr=0x1..0x5, no responses -> deq_c0 high for exactly 4 cycles; qlp_c0_rd_valid pulses carry hdr 0x1..0x4 one cycle later; credits_avail goes 4,3,2,1,0; 5th request waits.
REQ-038 From credits_avail=0, one qlp_c0_rx_rd_valid pulse -> credits_avail=1 next cycle; hdr 0x5 is issued that cycle; its output appears on the following cycle.
REQ-039 credits_avail=2, buf valid, issue and response coincide for 10 cycles -> credits_avail stays 2; 10 consecutive qlp_c0_rd_valid pulses.
REQ-040 qlp_c0_almfull asserted for cycles 3-7 with buf valid throughout -> deq_c0=0 in cycles 3-7; no qlp_c0_rd_valid in cycles 4-8; issue resumes in cycle 8.
REQ-041 Issue 3 reads, assert reset for 1 cycle, then 3 responses -> after reset credits_avail=4; first response sets credit_err=1; credits_avail stays 4.
REQ-042 MAX_RD_IN_FLIGHT=1, alternating issue/response -> credits_avail toggles 1/0; credit_err stays 0.
